// File: rtl/ring_monitor.sv
// Checks the one-hot ring sequence: lock on a valid step, count revolutions, flag illegal/bad/stalled codes.
// Latency: one edge; classification of ring_q against prev lands on outputs after the same edge.
// Backpressure: none; every edge is consumed. Optional irq output under macro RING_MONITOR_IRQ_EN.
module ring_monitor #(
    parameter int WIDTH     = 4,
    parameter int DIR       = 0,
    parameter int STALL_MAX = 8,
    parameter int REV_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ring_q,
    input  logic             clr,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             stall,
    output logic [REV_W-1:0] rev_count,
    output logic [7:0]       err_count
`ifdef RING_MONITOR_IRQ_EN
    ,
    output logic             irq
`endif
);

    typedef enum logic [1:0] {
        SEEK  = 2'b00,
        LOCK  = 2'b01,
        FAULT = 2'b10
    } state_t;

    // Hold counter only needs to reach STALL_MAX.
    localparam int              HW        = $clog2(STALL_MAX + 1);
    localparam logic [HW-1:0]   STALL_LIM = HW'(STALL_MAX);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic             err_onehot_q, err_onehot_d;
    logic             err_seq_q, err_seq_d;
    logic             stall_q, stall_d;
    logic [REV_W-1:0] rev_count_q, rev_count_d;
    logic [7:0]       err_count_q, err_count_d;

    logic             is_onehot, prev_onehot, is_hold, is_step, is_wrap;
    logic [WIDTH-1:0] rot;
    logic             ev_onehot, ev_seq, ev_stall, rev_inc, err_any;

    // Classify the incoming code against the previously sampled one.
    always_comb begin
        is_onehot   = (ring_q != '0) && ((ring_q & (ring_q - WIDTH'(1))) == '0);
        prev_onehot = (prev_q != '0) && ((prev_q & (prev_q - WIDTH'(1))) == '0);
        rot         = (DIR == 0) ? {prev_q[WIDTH-2:0], prev_q[WIDTH-1]}
                                 : {prev_q[0], prev_q[WIDTH-1:1]};
        is_hold     = is_onehot && (ring_q == prev_q);
        is_step     = is_onehot && prev_onehot && (ring_q == rot);
        is_wrap     = is_step && ((DIR == 0) ? prev_q[WIDTH-1] : prev_q[0]);
    end

    // Lock FSM: next state, hold counting and per-edge error events (at most one per edge).
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        ev_onehot  = 1'b0;
        ev_seq     = 1'b0;
        ev_stall   = 1'b0;
        rev_inc    = 1'b0;
        case (state_q)
            SEEK: begin
                if (is_step) state_d = LOCK;
            end
            LOCK: begin
                if (!is_onehot) begin
                    ev_onehot = 1'b1;
                    state_d   = FAULT;
                end else if (is_hold) begin
                    if (hold_cnt_q + HW'(1) == STALL_LIM) begin
                        ev_stall = 1'b1;
                        state_d  = SEEK;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end else if (is_step) begin
                    rev_inc = is_wrap;
                end else begin
                    ev_seq  = 1'b1;
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (is_onehot) state_d = SEEK;
            end
            default: state_d = SEEK;
        endcase
    end

    // Sticky flags and counters; clr wins over any same-edge set or increment.
    always_comb begin
        prev_d  = ring_q;
        err_any = ev_onehot | ev_seq | ev_stall;
        if (clr) begin
            err_onehot_d = 1'b0;
            err_seq_d    = 1'b0;
            stall_d      = 1'b0;
            rev_count_d  = '0;
            err_count_d  = '0;
        end else begin
            err_onehot_d = err_onehot_q | ev_onehot;
            err_seq_d    = err_seq_q | ev_seq;
            stall_d      = stall_q | ev_stall;
            rev_count_d  = rev_count_q + REV_W'(rev_inc);
            err_count_d  = (err_any && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
        end
    end

`ifdef RING_MONITOR_IRQ_EN
    logic irq_q, irq_d;

    // Pulse only on a fresh 0->1 of a sticky flag, never on a clearing edge.
    always_comb begin
        irq_d = !clr && ((ev_onehot && !err_onehot_q) ||
                         (ev_seq && !err_seq_q) ||
                         (ev_stall && !stall_q));
    end

    // irq register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

    // State and status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SEEK;
            prev_q       <= '0;
            hold_cnt_q   <= '0;
            err_onehot_q <= 1'b0;
            err_seq_q    <= 1'b0;
            stall_q      <= 1'b0;
            rev_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            hold_cnt_q   <= hold_cnt_d;
            err_onehot_q <= err_onehot_d;
            err_seq_q    <= err_seq_d;
            stall_q      <= stall_d;
            rev_count_q  <= rev_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign locked     = (state_q == LOCK);
    assign state      = state_q;
    assign err_onehot = err_onehot_q;
    assign err_seq    = err_seq_q;
    assign stall      = stall_q;
    assign rev_count  = rev_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Bench for ring_monitor: directed scenarios plus random ring traffic, scored against a reference model.
// Expectations are queued by the stimulus process and popped by an independent monitor.
// Checks the irq pulse as well when RING_MONITOR_IRQ_EN is defined.
module tb_ring_monitor;
    localparam int W         = 4;
    localparam int STALL_MAX = 8;

    logic       clk;
    logic       reset;
    logic       clr;
    logic [3:0] ring_q;
    logic       locked;
    logic [1:0] state;
    logic       err_onehot;
    logic       err_seq;
    logic       stall;
    logic [7:0] rev_count;
    logic [7:0] err_count;
`ifdef RING_MONITOR_IRQ_EN
    logic       irq;
`endif

    ring_monitor #(.WIDTH(W), .DIR(0), .STALL_MAX(STALL_MAX), .REV_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .ring_q     (ring_q),
        .clr        (clr),
        .locked     (locked),
        .state      (state),
        .err_onehot (err_onehot),
        .err_seq    (err_seq),
        .stall      (stall),
        .rev_count  (rev_count),
        .err_count  (err_count)
`ifdef RING_MONITOR_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    typedef struct packed {
        logic [1:0] st;
        logic       lk;
        logic       eo;
        logic       es;
        logic       sl;
        logic [7:0] rc;
        logic [7:0] ec;
        logic       iq;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: 0 seeking, 1 locked, 2 faulted.
    int         m_st, m_hc, m_rc, m_ec;
    bit         m_eo, m_es, m_sl, m_irq;
    logic [3:0] m_prev;
    logic [3:0] cur;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1);
    end

    task automatic model_step();
        bit oh, poh, step, wrap, hold, eo, es, sl, ri;
        int pp, nxt;
        obs_t e;
        if (!reset) begin
            m_st = 0; m_hc = 0; m_rc = 0; m_ec = 0;
            m_eo = 0; m_es = 0; m_sl = 0; m_irq = 0;
            m_prev = 4'b0000;
        end else begin
            oh   = ($countones(ring_q) == 1);
            poh  = ($countones(m_prev) == 1);
            pp   = poh ? $clog2(m_prev) : 0;
            nxt  = (pp + 1) % W;
            step = oh && poh && (int'(ring_q) == (1 << nxt));
            wrap = step && (pp == W - 1);
            hold = oh && (ring_q == m_prev);
            eo = 0; es = 0; sl = 0; ri = 0;
            case (m_st)
                0: if (step) m_st = 1;
                1: begin
                    if (!oh) begin
                        eo = 1; m_st = 2;
                    end else if (hold) begin
                        m_hc = m_hc + 1;
                        if (m_hc == STALL_MAX) begin
                            sl = 1; m_st = 0;
                        end
                    end else if (step) begin
                        m_hc = 0; ri = wrap;
                    end else begin
                        es = 1; m_st = 2;
                    end
                end
                default: if (oh) m_st = 0;
            endcase
            if (m_st != 1) m_hc = 0;
            m_irq = !clr && ((eo && !m_eo) || (es && !m_es) || (sl && !m_sl));
            if (clr) begin
                m_eo = 0; m_es = 0; m_sl = 0; m_rc = 0; m_ec = 0;
            end else begin
                m_eo = m_eo | eo;
                m_es = m_es | es;
                m_sl = m_sl | sl;
                if ((eo || es || sl) && m_ec < 255) m_ec = m_ec + 1;
                m_rc = (m_rc + (ri ? 1 : 0)) % 256;
            end
            m_prev = ring_q;
        end
        e.st = 2'(m_st);
        e.lk = (m_st == 1);
        e.eo = m_eo;
        e.es = m_es;
        e.sl = m_sl;
        e.rc = 8'(m_rc);
        e.ec = 8'(m_ec);
`ifdef RING_MONITOR_IRQ_EN
        e.iq = m_irq;
`else
        e.iq = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] r, input logic c, input logic rs);
        @(negedge clk);
        ring_q = r;
        clr    = c;
        reset  = rs;
        cur    = r;
        model_step();
    endtask

    task automatic d(input logic [3:0] r);
        drive(r, 1'b0, 1'b1);
    endtask

    task automatic step_ring();
        if ($countones(cur) == 1) d({cur[2:0], cur[3]});
        else                      d(4'b0001);
    endtask

    // Assert reset between clock edges; the monitor samples on its falling edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_step();
    endtask

    // Monitor: every active clock edge or reset assertion presents a new output word.
    initial begin
        obs_t e, o;
        #2;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            o.st = state;
            o.lk = locked;
            o.eo = err_onehot;
            o.es = err_seq;
            o.sl = stall;
            o.rc = rev_count;
            o.ec = err_count;
`ifdef RING_MONITOR_IRQ_EN
            o.iq = irq;
`else
            o.iq = 1'b0;
`endif
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL no_expectation t=%0t got=%h required a queued entry", $time, o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got st=%b lk=%b eo=%b es=%b sl=%b rc=%0d ec=%0d iq=%b required st=%b lk=%b eo=%b es=%b sl=%b rc=%0d ec=%0d iq=%b",
                             $time, o.st, o.lk, o.eo, o.es, o.sl, o.rc, o.ec, o.iq,
                             e.st, e.lk, e.eo, e.es, e.sl, e.rc, e.ec, e.iq);
                end
            end
        end
    end

    initial begin
        int r;
        reset  = 1'b0;
        clr    = 1'b0;
        ring_q = 4'b0001;
        cur    = 4'b0001;
        model_step();
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 1'b0);
        // Idle hold after release: must stay seeking without flags.
        for (int i = 0; i < 20; i++) drive(4'b0001, 1'b0, 1'b1);
        // Normal rotation: four revolutions' worth of steps.
        for (int i = 0; i < 16; i++) step_ring();
        // Illegal code while locked, then recover and relock.
        d(4'b0110);
        d(4'b0001);
        d(4'b0010);
        // Bad sequence: 0001 followed by 0100.
        d(4'b0100);
        d(4'b1000);
        d(4'b0001);
        d(4'b0100);
        // Stall: 7 holds are fine, 8 holds declare a stall.
        d(4'b0001);
        d(4'b0010);
        for (int i = 0; i < 7; i++) d(4'b0010);
        d(4'b0100);
        for (int i = 0; i < 8; i++) d(4'b0100);
        // All flags set: clear on the same edge as an illegal sample.
        d(4'b1000);
        drive(4'b0000, 1'b1, 1'b1);
        // Error count saturation.
        for (int i = 0; i < 260; i++) begin
            d(4'b0001);
            d(4'b0010);
            d(4'b1000);
        end
        drive(4'b0001, 1'b1, 1'b1);
        // Revolution counter wraps past 255.
        d(4'b0010);
        for (int i = 0; i < 1040; i++) step_ring();
        // Reset mid-revolution, then relock.
        async_reset();
        drive(4'b0001, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step_ring();
        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      step_ring();
            else if (r < 85) drive(cur, ($urandom_range(0, 49) == 0), 1'b1);
            else if (r < 92) drive(4'($urandom_range(0, 15)), 1'b0, 1'b1);
            else             drive(4'b0001 << $urandom_range(0, 3), ($urandom_range(0, 9) == 0), 1'b1);
            if (r == 0) begin
                for (int k = 0; k < STALL_MAX; k++) d(cur);
            end
        end
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unconsumed expectations, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_monitor.md
Name: ring_monitor

Overview:
- Checker stage that sits directly downstream of the 4-bit ring counter and consumes its one-hot q output.
- Verifies that the sequence is legal: the code is one-hot and it rotates in the configured direction or holds.
- Locks onto a valid sequence, counts full revolutions, and reports sticky error/stall flags and a saturating error count for status/LED logic.

Parameters:
- WIDTH, 4: ring width in bits; must match the ring counter's q width.
- DIR, 0: expected rotation. 0 = left (0001->0010->0100->1000->0001); 1 = right.
- STALL_MAX, 8: number of consecutive hold edges while locked that declares a stall; minimum 2.
- REV_W, 8: width of the revolution counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted (0) clears all state immediately.
- ring_q  input  WIDTH  ring counter output under check.
- clr  input  1  synchronous clear of sticky flags and counters; does not change state.
- locked  output  1  1 while state == LOCK.
- state  output  2  00 SEEK, 01 LOCK, 10 FAULT.
- err_onehot  output  1  sticky: a non-one-hot code was seen while locked.
- err_seq  output  1  sticky: a one-hot code arrived that is neither the expected rotation nor a hold.
- stall  output  1  sticky: the ring held for STALL_MAX edges while locked.
- rev_count  output  REV_W  completed revolutions; wraps modulo 2^REV_W.
- err_count  output  8  error events (onehot + seq + stall); saturates at 255.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=SEEK.
  - prev=0 (internal copy of the last ring_q).
  - hold_cnt=0.
  - All outputs 0.
- Each rising edge:
  - prev <= ring_q.
  - The classification below uses the current ring_q against prev; results appear on outputs after that same edge (latency 1 edge).
- Classification of ring_q against prev:
  - ILLEGAL: ring_q is not one-hot (0 or >1 bits set).
  - HOLD: ring_q == prev.
  - STEP: ring_q == rotate(prev, DIR).
  - WRAP: a STEP out of the end bit. DIR=0: prev MSB set -> LSB. DIR=1: prev LSB set -> MSB.
  - BAD: one-hot but none of the above.
- State transitions:
  - SEEK -> LOCK on STEP with prev one-hot. Otherwise stay in SEEK; no errors are flagged in SEEK.
  - LOCK, STEP: stay. hold_cnt=0. rev_count+1 on WRAP.
  - LOCK, HOLD: hold_cnt+1. When hold_cnt reaches STALL_MAX: stall=1, err_count+1, state -> SEEK, hold_cnt=0.
  - LOCK, ILLEGAL: err_onehot=1, err_count+1, state -> FAULT.
  - LOCK, BAD: err_seq=1, err_count+1, state -> FAULT.
  - FAULT -> SEEK on the first edge where ring_q is one-hot; otherwise stay. No further error counting while in FAULT.
- At most one error event per edge, so err_count increments by at most 1 per edge.
- err_count holds at 255; rev_count wraps 255->0 (REV_W=8).
- clr=1 on an edge:
  - Sticky flags, rev_count and err_count become 0. This overrides any same-edge set or increment (clear wins).
  - State transitions and hold_cnt still update normally.
- Reset asserted mid-operation: all outputs go to 0 without waiting for a clock edge. After release, the block re-enters SEEK and needs one STEP to lock.

Optional Feature:
- Macro: RING_MONITOR_IRQ_EN.
- Defined:
  - Adds output irq (1 bit), a registered single-cycle pulse on any edge where err_onehot, err_seq or stall transitions 0->1.
  - irq does not pulse if a flag was already set.
  - irq is suppressed on an edge where clr=1.
  - irq resets to 0.
- Undefined: the irq port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: reset=0 with ring_q=0001 -> state=00, locked=0, all flags 0, both counts 0. Release reset and hold ring_q=0001 for 20 edges -> stays SEEK, no flags set.
- Normal lock: drive 0001,0010,0100,1000 repeating (DIR=0). locked=1 after the 0010 edge; rev_count=3 after the third 1000->0001 edge; flags remain 0.
- Illegal code: while locked, inject 0110 -> next edge state=10, err_onehot=1, err_count=1, locked=0. Then 0001 -> SEEK; then 0010 -> LOCK; err_onehot stays 1.
- Bad sequence: while locked, 0001 then 0100 -> err_seq=1, err_count=1, state=FAULT. Separately, 255+ injected errors -> err_count holds at 255.
- Stall: while locked, hold 0010 for 7 edges -> no stall. Hold for 8 edges -> stall=1 on the 8th edge, state=SEEK, err_count+1. With RING_MONITOR_IRQ_EN defined, irq pulses for exactly one cycle.
- Clear/async reset: with all flags set, clr=1 on the same edge as an ILLEGAL sample -> flags and counts 0, state=FAULT. Assert reset mid-revolution between clock edges -> outputs 0 before the next clk edge.
